ram_test_sequencer: RTL

Self-checking stimulus stage that sits directly upstream of the on-device RAM skeleton. On a start trigger it drives the skeleton's enable, write-enable, address and data bus through a full write sweep and then a full read sweep, and compares each read word against the regenerated pattern. It reports the mismatch count and the first failing address to the host-side readout.

---
 rtl/ram_test_sequencer_pkg.sv | 25 ++
 rtl/ram_seq_pattern_gen.sv | 52 +++++
 rtl/ram_test_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ram_test_sequencer_pkg.sv
// Shared definitions for the RAM test sequencer: state encoding, pattern
// constants and the error-counter width helper.
// Optional feature macro: RAM_SEQ_LFSR_EN (selects the LFSR pattern source).
package ram_test_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Alternating-nibble constant; MSB-aligned slices give 0x5A5..., 0x5A5A...
  localparam logic [31:0] ALT_BITS = 32'h5A5A_5A5A;

  // ERR_CNT must hold the full depth 2**adr_width without saturating
  function automatic int err_cnt_width(input int adr_width);
    return adr_width + 1;
  endfunction

endpackage

// File: rtl/ram_seq_pattern_gen.sv
// Test-pattern source for the RAM sequencer. clear restarts the sequence at
// word 0, step advances one word. The generator is chosen by RAM_SEQ_LFSR_EN:
// defined   -> 16-bit Fibonacci LFSR seeded with SEED, low bits used
// undefined -> word index XOR the alternating-bit constant
module ram_seq_pattern_gen
  import ram_test_sequencer_pkg::*;
#(
  parameter int          BITWIDTH_IN = 12,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   step,
  output logic [BITWIDTH_IN-1:0] pattern
);

`ifdef RAM_SEQ_LFSR_EN
  logic [15:0] lfsr;
  logic        feedback;

  assign feedback = ^(lfsr & LFSR_TAPS);

  // LFSR register: reseeded on clear, shifted once per word
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        lfsr <= SEED;
    else if (clear) lfsr <= SEED;
    else if (step)  lfsr <= {lfsr[14:0], feedback};
  end

  assign pattern = BITWIDTH_IN'(lfsr);
`else
  // A BITWIDTH_IN-wide index equals the address truncated or zero-extended
  // to the payload width, since it starts at 0 and steps with the address.
  localparam logic [BITWIDTH_IN-1:0] ALT_MASK = BITWIDTH_IN'(ALT_BITS >> (32 - BITWIDTH_IN));

  logic [BITWIDTH_IN-1:0] index;
  logic                   unused_seed;

  assign unused_seed = ^SEED;

  // Word index: restarted on clear, incremented once per word
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        index <= '0;
    else if (clear) index <= '0;
    else if (step)  index <= index + 1'b1;
  end

  assign pattern = index ^ ALT_MASK;
`endif

endmodule

// File: rtl/ram_test_sequencer.sv
// RAM test sequencer: on TRGG_START sweeps the RAM skeleton with a full
// write pass then a full read pass, comparing each read payload against the
// regenerated pattern; reports mismatch count and first failing address.
// Optional feature macro: RAM_SEQ_LFSR_EN (LFSR pattern instead of addr^0x5A5...).
//
// state | meaning
// IDLE  | waiting for start, results held
// WRITE | writing pattern to addresses 0..N-1
// READ  | reading addresses 0..N-1, compare lags one cycle
// DRAIN | RAM idle, comparing the last read word
// DONE  | one-cycle DONE pulse, results valid
module ram_test_sequencer
  import ram_test_sequencer_pkg::*;
#(
  parameter int          BITWIDTH_IN  = 12,
  parameter int          BITWIDTH_SYS = 16,
  parameter int          BITWIDTH_ADR = 6,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                    CLK_SYS,
  input  logic                    RST,
  input  logic                    TRGG_START,
  output logic                    RAM_EN,
  output logic                    RAM_WE,
  output logic [BITWIDTH_ADR-1:0] RAM_ADR,
  output logic [BITWIDTH_SYS-1:0] RAM_DIN,
  input  logic [BITWIDTH_SYS-1:0] RAM_DOUT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [BITWIDTH_ADR:0]   ERR_CNT,
  output logic [BITWIDTH_ADR-1:0] ERR_FIRST_ADR,
  output logic                    ERR_FLAG
);

  localparam int                      ERR_W    = err_cnt_width(BITWIDTH_ADR);
  localparam int                      PAD_W    = BITWIDTH_SYS - BITWIDTH_IN;
  localparam logic [BITWIDTH_ADR-1:0] ADR_LAST = '1;

  seq_state_e              state_q, state_d;
  logic [BITWIDTH_ADR-1:0] cnt_q, cnt_d;
  logic                    gen_clear, gen_step;
  logic                    clr_res;
  logic                    sample_exp;
  logic [BITWIDTH_IN-1:0]  pattern;

  logic                    ram_en_q, ram_we_q, busy_q, done_q;
  logic                    cmp_vld_q;
  logic [BITWIDTH_IN-1:0]  exp_q;
  logic [BITWIDTH_ADR-1:0] exp_adr_q;
  logic [BITWIDTH_IN-1:0]  dout_payload;
  logic                    mismatch;
  logic                    unused_dout_pad;

  logic [ERR_W-1:0]        err_cnt_q;
  logic [BITWIDTH_ADR-1:0] err_first_q;
  logic                    err_flag_q;

  ram_seq_pattern_gen #(
    .BITWIDTH_IN (BITWIDTH_IN),
    .SEED        (SEED)
  ) u_pattern_gen (
    .clk     (CLK_SYS),
    .rst     (RST),
    .clear   (gen_clear),
    .step    (gen_step),
    .pattern (pattern)
  );

  // State and address counter registers
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and pattern-generator control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gen_clear  = 1'b0;
    gen_step   = 1'b0;
    clr_res    = 1'b0;
    sample_exp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (TRGG_START) begin
          state_d   = ST_WRITE;
          cnt_d     = '0;
          gen_clear = 1'b1;
          clr_res   = 1'b1;
        end
      end
      ST_WRITE: begin
        if (cnt_q == ADR_LAST) begin
          state_d   = ST_READ;
          cnt_d     = '0;
          gen_clear = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          gen_step = 1'b1;
        end
      end
      ST_READ: begin
        sample_exp = 1'b1;
        if (cnt_q == ADR_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          gen_step = 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered RAM strobes and status, decoded from the upcoming state
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ram_en_q <= (state_d == ST_WRITE) || (state_d == ST_READ);
      ram_we_q <= (state_d == ST_WRITE);
      busy_q   <= (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
      done_q   <= (state_d == ST_DONE);
    end
  end

  // Expected word and address delayed one cycle to line up with read data
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      cmp_vld_q <= 1'b0;
      exp_q     <= '0;
      exp_adr_q <= '0;
    end else begin
      cmp_vld_q <= sample_exp;
      if (sample_exp) begin
        exp_q     <= pattern;
        exp_adr_q <= cnt_q;
      end
    end
  end

  // Only the payload MSBs are compared; the padding LSBs are don't-care
  assign dout_payload    = RAM_DOUT[BITWIDTH_SYS-1 -: BITWIDTH_IN];
  assign unused_dout_pad = ^RAM_DOUT[PAD_W-1:0];
  assign mismatch        = cmp_vld_q && (dout_payload != exp_q);

  // Result registers: cleared on an accepted start, held otherwise
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      err_cnt_q   <= '0;
      err_first_q <= '0;
      err_flag_q  <= 1'b0;
    end else if (clr_res) begin
      err_cnt_q   <= '0;
      err_first_q <= '0;
      err_flag_q  <= 1'b0;
    end else if (mismatch) begin
      err_cnt_q  <= err_cnt_q + 1'b1;
      err_flag_q <= 1'b1;
      if (err_cnt_q == '0) err_first_q <= exp_adr_q;
    end
  end

  assign RAM_EN        = ram_en_q;
  assign RAM_WE        = ram_we_q;
  assign RAM_ADR       = cnt_q;
  assign RAM_DIN       = ram_we_q ? {pattern, {PAD_W{1'b0}}} : '0;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign ERR_CNT       = err_cnt_q;
  assign ERR_FIRST_ADR = err_first_q;
  assign ERR_FLAG      = err_flag_q;

endmodule
